imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side companion of the instruction memory: receives a byte stream (valid/ready),
//  assembles little-endian 32-bit words and writes them sequentially into the
//  instruction memory write port from word 0. Holds the CPU (cpu_hold) while loading.
//  Sits between the host byte link (e.g. UART rx) and the imem write port.
// PARAMETERS
//  INS_ADDRESS  9   byte-address width of imem; depth = 2**(INS_ADDRESS-2) words (128)
//  INS_W        32  instruction word width; fixed at 4 bytes per word
// PORTS
//  clk        in   1            single clock, all logic rising-edge
//  reset      in   1            synchronous, active-high
//  start      in   1            1-cycle pulse: begin a load (ignored unless IDLE/DONE/ERR)
//  rx_valid   in   1            byte available on rx_data
//  rx_data    in   8            stream byte
//  rx_ready   out  1            loader accepts byte; transfer = rx_valid & rx_ready
//  we         out  1            imem write enable, 1-cycle pulse per word
//  wa         out  INS_ADDRESS  imem byte address, word aligned (wa[1:0]=0)
//  wd         out  INS_W        imem write data
//  cpu_hold   out  1            1 while load in progress; CPU kept in reset
//  done       out  1            level: image loaded successfully
//  err        out  1            level: header word count exceeds depth
// BEHAVIOUR
//  Reset: state IDLE; rx_ready=0, we=0, wa=0, wd=0, cpu_hold=0, done=0, err=0; counters 0.
//  Stream format: CNT_LO, CNT_HI (16-bit word count N), then N words, 4 bytes each,
//   first byte -> wd[7:0], fourth -> wd[31:24].
//  States: IDLE, HDR_LO, HDR_HI, DATA, WRITE, DONE, ERR.
//   IDLE/DONE/ERR --start--> HDR_LO; clears done, err, word index, byte index.
//   HDR_LO --xfer--> HDR_HI (latch cnt[7:0]).
//   HDR_HI --xfer--> latch cnt[15:8]; N==0 -> DONE; N>DEPTH -> ERR; else DATA.
//   DATA: each xfer shifts byte into assembler; 4th byte of word -> WRITE.
//   WRITE: one cycle; we=1, wa={word_idx,2'b00}, wd=assembled word; word_idx++;
//     word_idx+1==N -> DONE else DATA.
//  rx_ready=1 only in HDR_LO, HDR_HI, DATA (0 in WRITE: one-cycle bubble per word).
//  cpu_hold=1 in HDR_LO..WRITE; 0 in IDLE, DONE, ERR. done=1 only in DONE; err=1 only in ERR.
//  Latency: 4th byte accepted in cycle t -> we=1 in cycle t+1.
//  wa/wd registered; hold last value outside WRITE; we=0 outside WRITE.
//  rx_valid low stalls without state change; bytes with rx_ready=0 are not consumed.
//  N==DEPTH (128): last write at wa=0x1FC, no wrap; word_idx never exceeds N-1.
//  start in HDR_LO..WRITE ignored. Reset mid-load: abort immediately to reset values;
//   partially written imem contents left as-is.
//  Width rules: word_idx is INS_ADDRESS-2 bits (+1 compare bit); cnt compared at 16 bits.
// STRUCTURE
//  imem_loader_pkg: state enum loader_state_t, localparam WORDS_PER_INS=4,
//   function depth(INS_ADDRESS) = 2**(INS_ADDRESS-2).
//  Sub-module word_assembler: byte shift-in, 2-bit byte index, word_valid at 4th byte,
//   clear input; parent FSM owns header, indices, write port.
// TESTING
//  Reset: assert reset 2 cycles -> all outputs 0, rx_ready=0, state IDLE.
//  Load 2 words: start; bytes 02 00 | 13 00 00 00 | B3 00 00 00 ->
//   we pulses: wa=0x000 wd=0x00000013, wa=0x004 wd=0x000000B3; done=1, cpu_hold=0.
//  Backpressure: rx_valid toggled randomly, byte after each 4th held during WRITE ->
//   no byte lost or duplicated; rx_ready=0 exactly the WRITE cycle.
//  Boundary: N=0 -> DONE after header, no we; N=128 -> last wa=0x1FC; N=129 (81 00) -> err=1, no we.
//  Reset mid-load: reset after 5 data bytes -> next cycle all outputs 0; new start loads cleanly.
//  start during DATA ignored (byte/word indices unchanged); start from DONE reloads from wa=0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } loader_state_t;

  localparam int unsigned WORDS_PER_INS = 4;

  function automatic int unsigned depth(input int unsigned ins_address);
    return 32'd1 << (ins_address - 32'd2);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembler: first byte lands in bits [7:0].
module imem_loader_word_assembler
  import imem_loader_pkg::*;
#(
  parameter int unsigned INS_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_shift_en,
  input  logic [7:0]       i_byte,
  output logic [INS_W-1:0] o_word,
  output logic             o_word_valid
);

  localparam logic [1:0] LAST_BYTE = 2'(WORDS_PER_INS - 1);

  logic [INS_W-1:0] r_word;
  logic [1:0]       r_idx;
  logic [INS_W-1:0] w_word;

  // Presents the word including the byte being shifted in this cycle.
  assign w_word       = {i_byte, r_word[INS_W-1:8]};
  assign o_word       = w_word;
  assign o_word_valid = i_shift_en & (r_idx == LAST_BYTE);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_shift_en) begin
      r_word <= w_word;
      r_idx  <= r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into the instruction memory, holding the CPU meanwhile.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned INS_ADDRESS = 9,
  parameter int unsigned INS_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic                   we,
  output logic [INS_ADDRESS-1:0] wa,
  output logic [INS_W-1:0]       wd,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned IDX_W = INS_ADDRESS - 2;
  localparam logic [16:0] DEPTH = 17'(depth(INS_ADDRESS));

  loader_state_t    r_state;
  logic [IDX_W-1:0] r_word_idx;
  logic [15:0]      r_cnt;

  logic             w_xfer;
  logic             w_restart;
  logic             w_word_valid;
  logic [INS_W-1:0] w_word;
  logic [15:0]      w_hdr;
  logic             w_last;

  assign w_xfer    = rx_valid & rx_ready;
  assign w_restart = start & (r_state inside {S_IDLE, S_DONE, S_ERR});
  assign w_hdr     = {rx_data, r_cnt[7:0]};
  assign w_last    = (16'(r_word_idx) + 16'd1) == r_cnt;

  imem_loader_word_assembler #(
    .INS_W(INS_W)
  ) u_asm (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_clear     (w_restart),
    .i_shift_en  (w_xfer && (r_state == S_DATA)),
    .i_byte      (rx_data),
    .o_word      (w_word),
    .o_word_valid(w_word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_word_idx <= '0;
      r_cnt      <= '0;
      rx_ready   <= 1'b0;
      we         <= 1'b0;
      wa         <= '0;
      wd         <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state    <= S_HDR_LO;
            r_word_idx <= '0;
            r_cnt      <= '0;
            rx_ready   <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
          end
        end
        S_HDR_LO: begin
          if (w_xfer) begin
            r_cnt[7:0] <= rx_data;
            r_state    <= S_HDR_HI;
          end
        end
        S_HDR_HI: begin
          if (w_xfer) begin
            r_cnt[15:8] <= rx_data;
            if (w_hdr == 16'd0) begin
              r_state  <= S_DONE;
              rx_ready <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else if ({1'b0, w_hdr} > DEPTH) begin
              r_state  <= S_ERR;
              rx_ready <= 1'b0;
              cpu_hold <= 1'b0;
              err      <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_word_valid) begin
            r_state  <= S_WRITE;
            rx_ready <= 1'b0;
            we       <= 1'b1;
            wa       <= {r_word_idx, 2'b00};
            wd       <= w_word;
          end
        end
        S_WRITE: begin
          we <= 1'b0;
          // Index stops at N-1 so a full-depth image never wraps it.
          if (w_last) begin
            r_state  <= S_DONE;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else begin
            r_word_idx <= r_word_idx + 1'b1;
            r_state    <= S_DATA;
            rx_ready   <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes and status, monitor compares.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, we, cpu_hold, done, err;
  logic [8:0]  wa;
  logic [31:0] wd;

  always #5 clk = ~clk;

  imem_loader #(
    .INS_ADDRESS(9),
    .INS_W      (32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .rx_ready(rx_ready),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .cpu_hold(cpu_hold),
    .done    (done),
    .err     (err)
  );

  typedef struct {logic [8:0] wa; logic [31:0] wd;} wr_t;
  typedef struct {string nm; logic [45:0] mask; logic [45:0] exp;} chk_t;

  localparam logic [45:0] M_RDY   = 46'd1 << 45;
  localparam logic [45:0] M_WE    = 46'd1 << 44;
  localparam logic [45:0] M_HOLD  = 46'd1 << 43;
  localparam logic [45:0] M_DONE  = 46'd1 << 42;
  localparam logic [45:0] M_ERR   = 46'd1 << 41;
  localparam logic [45:0] M_WA    = 46'h1FF << 32;
  localparam logic [45:0] M_ALL   = '1;
  localparam logic [45:0] M_FLAGS = M_RDY | M_WE | M_HOLD | M_DONE | M_ERR;

  wr_t         wq[$];
  chk_t        cq[$];
  logic [31:0] words_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  bit          tb_done = 1'b0;
  logic [45:0] stat;

  assign stat = {rx_ready, we, cpu_hold, done, err, wa, wd};

  function automatic logic [45:0] flags(input bit rdy, input bit wen, input bit hold,
                                        input bit dn, input bit er);
    return {rdy, wen, hold, dn, er, 41'b0};
  endfunction

  // Monitor: samples 2 time units after each falling edge.
  chk_t c;
  wr_t  e;
  always @(negedge clk) begin
    #2;
    while (cq.size() > 0) begin
      c = cq.pop_front();
      n_vec++;
      if ((stat & c.mask) !== (c.exp & c.mask)) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", c.nm, stat & c.mask, c.exp & c.mask);
      end
    end
    if (!reset) begin
      n_vec++;
      if (rx_ready !== (cpu_hold & ~we)) begin
        n_bad++;
        $display("FAIL rdy_rule: rx_ready=%b want %b (hold=%b we=%b)",
                 rx_ready, cpu_hold & ~we, cpu_hold, we);
      end
      if (we === 1'b1) begin
        n_vec++;
        if (wq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_we: wa=%h wd=%h want no write", wa, wd);
        end else begin
          e = wq.pop_front();
          if ({wa, wd} !== {e.wa, e.wd}) begin
            n_bad++;
            $display("FAIL write: got wa=%h wd=%h want wa=%h wd=%h", wa, wd, e.wa, e.wd);
          end
        end
      end
    end
    if (tb_done) begin
      n_vec++;
      if (wq.size() != 0) begin
        n_bad++;
        $display("FAIL missing_writes: got %0d pending want 0", wq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
    end
  end

  task automatic push_chk(input string nm, input logic [45:0] mask, input logic [45:0] exp);
    cq.push_back('{nm, mask, exp});
  endtask

  // Called at a falling edge; returns at the falling edge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit bp);
    int unsigned gap;
    gap = bp ? $urandom_range(0, 3) : 0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t <= 40; t++) begin
      if (rx_ready) break;
      if (t == 40) begin
        push_chk("rx_ready_timeout", M_RDY, M_RDY);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input bit exp_done, input bit exp_err);
    for (int t = 0; t < 20 && !(done | err); t++) @(negedge clk);
    push_chk("end_flags", M_FLAGS, flags(1'b0, 1'b0, 1'b0, exp_done, exp_err));
    @(negedge clk);
  endtask

  task automatic load(input logic [15:0] n, input int unsigned nw, input bit bp,
                      input bit exp_done, input bit exp_err);
    logic [31:0] w;
    pulse_start();
    send_byte(n[7:0], bp);
    send_byte(n[15:8], bp);
    for (int unsigned i = 0; i < nw; i++) begin
      w = words_q[i];
      wq.push_back('{9'(i * 4), w});
      for (int unsigned k = 0; k < 4; k++) send_byte(w[8*k +: 8], bp);
      push_chk("latency", M_WE, M_WE);
    end
    wait_end(exp_done, exp_err);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    push_chk("reset", M_ALL, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Two-word image: 02 00 | 13 00 00 00 | B3 00 00 00
    words_q = '{32'h0000_0013, 32'h0000_00B3};
    load(16'd2, 2, 1'b0, 1'b1, 1'b0);

    // Reload from DONE with random valid gaps
    words_q = '{32'h1122_3344, 32'hDEAD_BEEF, 32'h0055_AA01};
    load(16'd3, 3, 1'b1, 1'b1, 1'b0);

    // Empty image
    load(16'd0, 0, 1'b1, 1'b1, 1'b0);

    // One word over depth (81 00)
    load(16'h0081, 0, 1'b0, 1'b0, 1'b1);

    // Full depth from ERR; last write lands at 0x1FC
    words_q.delete();
    for (int k = 0; k < 128; k++)
      words_q.push_back({8'(k), 8'(k ^ 8'hFF), 8'h3C, 8'(3 * k)});
    load(16'd128, 128, 1'b0, 1'b1, 1'b0);
    push_chk("last_wa", M_WA, {5'b0, 9'h1FC, 32'b0});
    @(negedge clk);

    // start during DATA must not disturb the load in progress
    wq.push_back('{9'h000, 32'h1234_5678});
    wq.push_back('{9'h004, 32'h89AB_CDEF});
    pulse_start();
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h78, 1'b0); send_byte(8'h56, 1'b0);
    pulse_start();
    send_byte(8'h34, 1'b0); send_byte(8'h12, 1'b0);
    push_chk("latency", M_WE, M_WE);
    send_byte(8'hEF, 1'b1); send_byte(8'hCD, 1'b1);
    send_byte(8'hAB, 1'b1); send_byte(8'h89, 1'b1);
    push_chk("latency", M_WE, M_WE);
    wait_end(1'b1, 1'b0);

    // Reset after 5 data bytes, then a clean single-word load
    wq.push_back('{9'h000, 32'h0403_0201});
    pulse_start();
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b0);
    push_chk("latency", M_WE, M_WE);
    send_byte(8'h05, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    push_chk("reset_mid", M_ALL, '0);
    reset = 1'b0;
    @(negedge clk);
    words_q = '{32'hCAFE_F00D};
    load(16'd1, 1, 1'b1, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    tb_done = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish before 500000");
    $fatal(1);
  end

endmodule
